// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N byte-stream requesters
// A granted requester keeps the UART until its Last byte is accepted; a watchdog aborts unacknowledged bytes.
module tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           i_clock,
  input  logic           i_resetn,
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_last,
  input  logic [8*N-1:0] i_data_in,
  output logic [N-1:0]   o_ack,
  output logic [N-1:0]   o_grant,
  input  logic           i_tx_empty,
  output logic           o_xmit_go,
  output logic [7:0]     o_tx_data,
  output logic           o_timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [N-1:0]  r_ack, w_ack_nxt;
  logic          r_xmit, w_xmit_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [N-1:0]  w_win_onehot;
  logic [IW-1:0] w_owner_inc;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    if (v >= N) return IW'(v - N);
    return IW'(v);
  endfunction

  // Descending scan so the requester closest to the pointer is the final assignment.
  always_comb begin
    w_found      = 1'b0;
    w_win        = '0;
    w_win_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(int'(r_ptr) + k)]) begin
        w_found      = 1'b1;
        w_win        = wrap_idx(int'(r_ptr) + k);
        w_win_onehot = '0;
        w_win_onehot[wrap_idx(int'(r_ptr) + k)] = 1'b1;
      end
    end
  end

  assign w_owner_inc = wrap_idx(int'(r_owner) + 1);

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = '0;
    w_xmit_nxt    = r_xmit;
    w_timeout_nxt = 1'b0;
    w_tx_data_nxt = r_tx_data;
    case (r_state)
      IDLE: begin
        if (i_tx_empty && w_found) begin
          w_owner_nxt   = w_win;
          w_grant_nxt   = w_win_onehot;
          w_tx_data_nxt = i_data_in[{w_win, 3'b000} +: 8];
          w_last_nxt    = i_last[w_win];
          w_xmit_nxt    = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = SEND;
        end
      end
      SEND: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // UART acceptance wins over a watchdog expiry in the same cycle.
        if (!i_tx_empty) begin
          w_xmit_nxt = 1'b0;
          w_ack_nxt  = r_grant;
          if (r_last) begin
            w_grant_nxt = '0;
            w_ptr_nxt   = w_owner_inc;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLD;
          end
        end else if (r_cnt == CNT_MAX) begin
          w_xmit_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
          w_grant_nxt   = '0;
          w_ptr_nxt     = w_owner_inc;
          w_state_nxt   = IDLE;
        end
      end
      HOLD: begin
        if (!i_req[r_owner]) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = IDLE;
        end else if (i_tx_empty) begin
          w_tx_data_nxt = i_data_in[{r_owner, 3'b000} +: 8];
          w_last_nxt    = i_last[r_owner];
          w_xmit_nxt    = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_xmit    <= 1'b0;
      r_timeout <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_xmit    <= w_xmit_nxt;
      r_timeout <= w_timeout_nxt;
      r_tx_data <= w_tx_data_nxt;
    end
  end

  assign o_ack     = r_ack;
  assign o_grant   = r_grant;
  assign o_xmit_go = r_xmit;
  assign o_tx_data = r_tx_data;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter with queued producers and a UART model
module tb_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req, last, ack, grant;
  logic [8*N-1:0] data_in;
  logic           tx_empty, xmit, tmo;
  logic [7:0]     tx_data;

  int checks = 0;
  int errors = 0;

  tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .i_clock    (clk),
    .i_resetn   (rstn),
    .i_req      (req),
    .i_last     (last),
    .i_data_in  (data_in),
    .o_ack      (ack),
    .o_grant    (grant),
    .i_tx_empty (tx_empty),
    .o_xmit_go  (xmit),
    .o_tx_data  (tx_data),
    .o_timeout  (tmo)
  );

  always #5 clk = ~clk;

  // Per-requester byte queues the producers drain on Ack
  logic [7:0]   q_data [N][64];
  logic         q_last [N][64];
  int           q_head [N];
  int           q_tail [N];
  logic [N-1:0] en;

  // UART model: TxEmpty falls u_delay cycles after XMitGo, stays low u_busy_len cycles
  int u_delay, u_busy_len, u_wait, u_busy;
  bit u_stuck;

  logic [N-1:0] req_at_edge, prev_grant;
  int           acked_idx;
  logic [7:0]   acked_exp;
  logic         acked_last;

  logic [N-1:0] log_a [16];
  logic [N-1:0] log_g [16];
  logic [7:0]   log_b [16];

  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && q_head[i] < q_tail[i]) begin
        req[i]          = 1'b1;
        last[i]         = q_last[i][q_head[i]];
        data_in[8*i+:8] = q_data[i][q_head[i]];
      end else begin
        req[i]          = 1'b0;
        last[i]         = 1'b0;
        data_in[8*i+:8] = 8'h00;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
    end
    en = '0;
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    q_data[i][q_tail[i]] = b;
    q_last[i][q_tail[i]] = l;
    q_tail[i]++;
  endtask

  task automatic cycle();
    req_at_edge = req;
    prev_grant  = grant;
    @(posedge clk);
    #1;
    if (u_stuck) begin
      tx_empty = 1'b1;
      u_wait   = 0;
    end else if (u_busy > 0) begin
      u_busy--;
      if (u_busy == 0) tx_empty = 1'b1;
    end else if (xmit) begin
      u_wait++;
      if (u_wait >= u_delay) begin
        tx_empty = 1'b0;
        u_busy   = u_busy_len;
        u_wait   = 0;
      end
    end else begin
      u_wait = 0;
    end
    acked_idx = -1;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        acked_idx  = i;
        acked_exp  = q_data[i][q_head[i]];
        acked_last = q_last[i][q_head[i]];
        if (q_head[i] < q_tail[i]) q_head[i]++;
      end
    end
    drive_reqs();
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 60; c++) begin
      if (tx_empty && u_busy == 0 && grant == '0) break;
      cycle();
    end
  endtask

  task automatic collect_acks(input int n, output int got);
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      cycle();
      if (acked_idx >= 0) begin
        log_a[got] = ack;
        log_g[got] = prev_grant;
        log_b[got] = tx_data;
        got++;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; tx_empty = 1'b1; u_stuck = 0; u_delay = 3; u_busy_len = 4;
    u_wait = 0; u_busy = 0;
    clear_queues();
    drive_reqs();
    cycle();
    cycle();
    checks++; if (grant !== '0)    begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
    checks++; if (ack !== '0)      begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (xmit !== 1'b0)   begin errors++; $display("FAIL reset_xmit got %b want 0", xmit); end
    checks++; if (tmo !== 1'b0)    begin errors++; $display("FAIL reset_timeout got %b want 0", tmo); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata got %h want 00", tx_data); end
    rstn = 1'b1;
  endtask

  task automatic test_single_byte();
    int n;
    bit seen;
    wait_idle();
    clear_queues();
    push(0, 8'h48, 1'b1);
    en = 4'b0001;
    drive_reqs();
    cycle();
    checks++; if (xmit !== 1'b1)     begin errors++; $display("FAIL single_latency xmit got %b want 1", xmit); end
    checks++; if (tx_data !== 8'h48) begin errors++; $display("FAIL single_txdata got %h want 48", tx_data); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", grant); end
    n = 1; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      cycle();
      if (ack != '0) seen = 1;
      else if (xmit) n++;
    end
    checks++; if (!seen)             begin errors++; $display("FAIL single_ack_seen got 0 want 1"); end
    checks++; if (ack !== 4'b0001)   begin errors++; $display("FAIL single_ack got %b want 0001", ack); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_free got %b want 0000", grant); end
    checks++; if (n != 3)            begin errors++; $display("FAIL single_xmit_len got %0d want 3", n); end
    cycle();
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL single_ack_pulse got %b want 0000", ack); end
  endtask

  task automatic test_rr_pair();
    int got;
    int exp_i [4] = '{1, 3, 1, 3};
    logic [7:0] exp_b [4] = '{8'h11, 8'h31, 8'h12, 8'h32};
    wait_idle();
    clear_queues();
    push(1, 8'h11, 1'b1); push(1, 8'h12, 1'b1);
    push(3, 8'h31, 1'b1); push(3, 8'h32, 1'b1);
    en = 4'b1010;
    drive_reqs();
    collect_acks(4, got);
    checks++; if (got != 4) begin errors++; $display("FAIL rr_count got %0d want 4", got); end
    for (int k = 0; k < got; k++) begin
      checks++; if (log_g[k] !== onehot(exp_i[k])) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, log_g[k], onehot(exp_i[k])); end
      checks++; if (log_a[k] !== onehot(exp_i[k])) begin errors++; $display("FAIL rr_ack[%0d] got %b want %b", k, log_a[k], onehot(exp_i[k])); end
      checks++; if (log_b[k] !== exp_b[k]) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", k, log_b[k], exp_b[k]); end
    end
  endtask

  task automatic test_message();
    int got;
    int exp_i [5] = '{2, 2, 2, 2, 0};
    logic [7:0] exp_b [5] = '{8'h48, 8'h69, 8'h21, 8'h0A, 8'h55};
    wait_idle();
    clear_queues();
    push(2, 8'h48, 1'b0); push(2, 8'h69, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h0A, 1'b1);
    push(0, 8'h55, 1'b1);
    en = 4'b0100;
    drive_reqs();
    cycle();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL msg_first_grant got %b want 0100", grant); end
    en = 4'b0101;
    drive_reqs();
    collect_acks(5, got);
    checks++; if (got != 5) begin errors++; $display("FAIL msg_count got %0d want 5", got); end
    for (int k = 0; k < got; k++) begin
      checks++; if (log_a[k] !== onehot(exp_i[k])) begin errors++; $display("FAIL msg_ack[%0d] got %b want %b", k, log_a[k], onehot(exp_i[k])); end
      checks++; if (log_b[k] !== exp_b[k]) begin errors++; $display("FAIL msg_data[%0d] got %h want %h", k, log_b[k], exp_b[k]); end
    end
  endtask

  task automatic test_timeout();
    int n, got;
    int exp_i [2] = '{3, 1};
    logic [7:0] exp_b [2] = '{8'hBB, 8'hAA};
    wait_idle();
    clear_queues();
    push(1, 8'hAA, 1'b1);
    push(3, 8'hBB, 1'b1);
    u_stuck = 1;
    en = 4'b1010;
    drive_reqs();
    cycle();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", grant); end
    n = (xmit === 1'b1) ? 1 : 0;
    for (int c = 0; c < 64 && xmit === 1'b1; c++) begin
      cycle();
      if (xmit) n++;
    end
    checks++; if (n != TO)           begin errors++; $display("FAIL to_xmit_len got %0d want %0d", n, TO); end
    checks++; if (tmo !== 1'b1)      begin errors++; $display("FAIL to_pulse got %b want 1", tmo); end
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL to_no_ack got %b want 0000", ack); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_grant_clear got %b want 0000", grant); end
    u_stuck = 0;
    cycle();
    checks++; if (tmo !== 1'b0)      begin errors++; $display("FAIL to_pulse_len got %b want 0", tmo); end
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL to_next_grant got %b want 1000", grant); end
    collect_acks(2, got);
    checks++; if (got != 2) begin errors++; $display("FAIL to_count got %0d want 2", got); end
    for (int k = 0; k < got; k++) begin
      checks++; if (log_a[k] !== onehot(exp_i[k])) begin errors++; $display("FAIL to_ack[%0d] got %b want %b", k, log_a[k], onehot(exp_i[k])); end
      checks++; if (log_b[k] !== exp_b[k]) begin errors++; $display("FAIL to_data[%0d] got %h want %h", k, log_b[k], exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int got;
    int exp_i [3] = '{0, 3, 3};
    logic [7:0] exp_b [3] = '{8'hD0, 8'hC1, 8'hC2};
    wait_idle();
    clear_queues();
    push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b1);
    push(0, 8'hD0, 1'b1);
    en = 4'b1001;
    drive_reqs();
    cycle();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rmid_grant got %b want 1000", grant); end
    rstn = 1'b0;
    cycle();
    checks++; if (xmit !== 1'b0)     begin errors++; $display("FAIL rmid_xmit got %b want 0", xmit); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_grant_clear got %b want 0000", grant); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_txdata got %h want 00", tx_data); end
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL rmid_ack got %b want 0000", ack); end
    rstn = 1'b1;
    cycle();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_prio got %b want 0001", grant); end
    collect_acks(3, got);
    checks++; if (got != 3) begin errors++; $display("FAIL rmid_count got %0d want 3", got); end
    for (int k = 0; k < got; k++) begin
      checks++; if (log_a[k] !== onehot(exp_i[k])) begin errors++; $display("FAIL rmid_ack[%0d] got %b want %b", k, log_a[k], onehot(exp_i[k])); end
      checks++; if (log_b[k] !== exp_b[k]) begin errors++; $display("FAIL rmid_data[%0d] got %h want %h", k, log_b[k], exp_b[k]); end
    end
  endtask

  task automatic test_hold_abandon();
    int got;
    wait_idle();
    clear_queues();
    u_busy_len = 1;
    push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b1);
    push(2, 8'hF0, 1'b1);
    en = 4'b0110;
    drive_reqs();
    collect_acks(1, got);
    checks++; if (got != 1 || log_a[0] !== 4'b0010) begin errors++; $display("FAIL hold_first_ack got %b want 0010", log_a[0]); end
    en[1] = 1'b0;
    drive_reqs();
    cycle();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL hold_release got %b want 0000", grant); end
    checks++; if (xmit !== 1'b0)     begin errors++; $display("FAIL hold_no_xmit got %b want 0", xmit); end
    cycle();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_next_grant got %b want 0100", grant); end
    checks++; if (tx_data !== 8'hF0) begin errors++; $display("FAIL hold_next_data got %h want F0", tx_data); end
    collect_acks(1, got);
    checks++; if (got != 1 || log_a[0] !== 4'b0100) begin errors++; $display("FAIL hold_next_ack got %b want 0100", log_a[0]); end
    u_busy_len = 4;
  endtask

  task automatic test_random();
    int total, got, m_ptr, m_owner, w, len;
    int st [N];
    logic [N-1:0] eg;
    wait_idle();
    clear_queues();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < 3; m++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1));
        total += len;
      end
      st[i] = $urandom_range(0, 40);
    end
    m_ptr = 0; m_owner = -1; got = 0;
    for (int c = 0; c < 3000 && got < total; c++) begin
      for (int i = 0; i < N; i++) if (c == st[i]) en[i] = 1'b1;
      drive_reqs();
      cycle();
      checks++;
      if ($countones(grant) > 1 || (ack != '0 && tmo) || tmo) begin
        errors++; $display("FAIL rand_invariant grant %b ack %b timeout %b", grant, ack, tmo);
      end
      if (grant != '0 && prev_grant == '0) begin
        w  = rr_pick(m_ptr, req_at_edge);
        eg = onehot(w);
        checks++;
        if (grant !== eg) begin errors++; $display("FAIL rand_grant got %b want %b", grant, eg); end
        checks++;
        if (w >= 0 && (xmit !== 1'b1 || tx_data !== q_data[w][q_head[w]])) begin
          errors++; $display("FAIL rand_first_byte got %h want %h", tx_data, q_data[w][q_head[w]]);
        end
        m_owner = w;
      end
      if (acked_idx >= 0) begin
        checks++;
        if (acked_idx != m_owner || tx_data !== acked_exp) begin
          errors++; $display("FAIL rand_ack got req %0d byte %h want req %0d byte %h", acked_idx, tx_data, m_owner, acked_exp);
        end
        got++;
        if (acked_last) m_ptr = (m_owner + 1) % N;
        u_delay    = $urandom_range(1, 3);
        u_busy_len = $urandom_range(1, 5);
      end
    end
    checks++; if (got != total) begin errors++; $display("FAIL rand_count got %0d want %0d", got, total); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit got running want finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; req = '0; last = '0; data_in = '0; tx_empty = 1'b1; en = '0;
    test_reset();
    test_single_byte();
    test_rr_pair();
    test_message();
    test_timeout();
    test_reset_mid();
    test_hold_abandon();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
